// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the SRAM arbiter and its grant picker.
package sram_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_DONE   = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      OWN_JTAG  = 2'd0,
      OWN_DATA  = 2'd1,
      OWN_FETCH = 2'd2
   } owner_t;

   localparam int ACCESS_CYCLES_DEF = 2;
   localparam int CNT_W             = 3;

   // Grant bit index equals the owner id: bit0 JTAG, bit1 DATA, bit2 FETCH.
   function automatic owner_t grant_to_owner(input logic [2:0] grant);
      owner_t o;
      o = OWN_FETCH;
      if (grant[0]) begin
         o = OWN_JTAG;
      end else if (grant[1]) begin
         o = OWN_DATA;
      end
      return o;
   endfunction

endpackage

// File: rtl/sram_grant_pick.sv
// Combinational winner selection: JTAG fixed highest priority, data/fetch
// round-robin on a tie (the one that did not win last time goes next).
module sram_grant_pick
   import sram_arbiter_pkg::*;
(
   input  logic       jtag_ok,
   input  logic       data_req,
   input  logic       fetch_req,
   input  owner_t     last_core,
   output logic [2:0] grant,
   output logic       valid
);

   // Pick one-hot grant from the eligible requests.
   always_comb begin
      grant = 3'b000;
      if (jtag_ok) begin
         grant = 3'b001;
      end else if (data_req && fetch_req) begin
         grant = (last_core == OWN_DATA) ? 3'b100 : 3'b010;
      end else if (data_req) begin
         grant = 3'b010;
      end else if (fetch_req) begin
         grant = 3'b100;
      end
   end

   assign valid = |grant;

endmodule

// File: rtl/sram_arbiter.sv
// Owns the external 16-bit SRAM and shares it between JTAG, core data and
// core fetch ports. Each access is IDLE -> ACCESS (ACCESS_CYCLES) -> DONE.
//
// Handshake (req/ack): a requester raises req with a stable payload and holds
// it until its one-cycle ack; the payload is sampled only in IDLE, and the
// requester drops req in the ack cycle. A req still high in the following
// IDLE is a new request. rdata is valid in the ack cycle.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        isPaused,
   input  logic        jtagReq,
   input  logic        jtagWr,
   input  logic [15:0] jtagAddr,
   input  logic [15:0] jtagWData,
   output logic        jtagAck,
   input  logic        dataReq,
   input  logic        dataWr,
   input  logic [15:0] dataAddr,
   input  logic [15:0] dataWData,
   output logic        dataAck,
   input  logic        fetchReq,
   input  logic [15:0] fetchAddr,
   output logic        fetchAck,
   output logic [15:0] rdata,
   output logic [15:0] sramAddr,
   inout  wire  [15:0] sramData,
   output logic        sramWr,
   output logic        sramEn,
   output state_t      dbg_state,
   output owner_t      dbg_last_core,
   output logic        dbg_bus_oe
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   owner_t            last_core_q, last_core_d;
   logic [15:0]       addr_q, addr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              wr_q, wr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [15:0]       rdata_q, rdata_d;

   logic [2:0]        pick_grant;
   logic              pick_valid;
   owner_t            pick_owner;

   sram_grant_pick u_pick (
      .jtag_ok   (jtagReq & isPaused),
      .data_req  (dataReq),
      .fetch_req (fetchReq),
      .last_core (last_core_q),
      .grant     (pick_grant),
      .valid     (pick_valid)
   );

   assign pick_owner = grant_to_owner(pick_grant);

   // Next-state logic: grant and latch in IDLE, count in ACCESS, ack in DONE.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_core_d = last_core_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wr_d        = wr_q;
      cnt_d       = cnt_q;
      rdata_d     = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               owner_d = pick_owner;
               cnt_d   = '0;
               state_d = ST_ACCESS;
               case (pick_owner)
                  OWN_JTAG: begin
                     addr_d  = jtagAddr;
                     wdata_d = jtagWData;
                     wr_d    = jtagWr;
                  end
                  OWN_DATA: begin
                     addr_d  = dataAddr;
                     wdata_d = dataWData;
                     wr_d    = dataWr;
                  end
                  default: begin
                     addr_d = fetchAddr;
                     wr_d   = 1'b0;
                  end
               endcase
               if (pick_owner != OWN_JTAG) begin
                  last_core_d = pick_owner;
               end
            end
         end
         ST_ACCESS: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               if (!wr_q) begin
                  rdata_d = sramData;
               end
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and latch registers; reset aborts any transaction without an ack.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_JTAG;
         last_core_q <= OWN_FETCH;
         addr_q      <= '0;
         wdata_q     <= '0;
         wr_q        <= 1'b0;
         cnt_q       <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_core_q <= last_core_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wr_q        <= wr_d;
         cnt_q       <= cnt_d;
         rdata_q     <= rdata_d;
      end
   end

   // sramAddr comes straight from the latch so it holds outside ACCESS.
   assign sramEn     = (state_q == ST_ACCESS);
   assign sramWr     = sramEn & wr_q;
   assign dbg_bus_oe = sramEn & wr_q;
   assign sramData   = dbg_bus_oe ? wdata_q : {16{1'bz}};
   assign sramAddr   = addr_q;
   assign rdata      = rdata_q;

   assign jtagAck  = (state_q == ST_DONE) && (owner_q == OWN_JTAG);
   assign dataAck  = (state_q == ST_DONE) && (owner_q == OWN_DATA);
   assign fetchAck = (state_q == ST_DONE) && (owner_q == OWN_FETCH);

   assign dbg_state     = state_q;
   assign dbg_last_core = last_core_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: grant-picker vector table, single
// transaction table, and hand-written multi-cycle sequences.
module tb_sram_arbiter;
   import sram_arbiter_pkg::*;

   localparam int AC = 2;

   logic        clk = 1'b0;
   logic        rstn;
   logic        is_paused;
   logic        jtag_req, jtag_wr, jtag_ack;
   logic [15:0] jtag_addr, jtag_wdata;
   logic        data_req, data_wr, data_ack;
   logic [15:0] data_addr, data_wdata;
   logic        fetch_req, fetch_ack;
   logic [15:0] fetch_addr;
   logic [15:0] rdata, sram_addr;
   wire  [15:0] sram_data;
   logic        sram_wr, sram_en;
   state_t      dbg_state;
   owner_t      dbg_last_core;
   logic        dbg_bus_oe;

   logic        pk_j, pk_d, pk_f, pk_valid;
   owner_t      pk_last;
   logic [2:0]  pk_grant;

   int total = 0;
   int bad   = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- DUT ----------------
   sram_arbiter #(.ACCESS_CYCLES(AC)) dut (
      .clk(clk), .rstn(rstn), .isPaused(is_paused),
      .jtagReq(jtag_req), .jtagWr(jtag_wr), .jtagAddr(jtag_addr),
      .jtagWData(jtag_wdata), .jtagAck(jtag_ack),
      .dataReq(data_req), .dataWr(data_wr), .dataAddr(data_addr),
      .dataWData(data_wdata), .dataAck(data_ack),
      .fetchReq(fetch_req), .fetchAddr(fetch_addr), .fetchAck(fetch_ack),
      .rdata(rdata), .sramAddr(sram_addr), .sramData(sram_data),
      .sramWr(sram_wr), .sramEn(sram_en),
      .dbg_state(dbg_state), .dbg_last_core(dbg_last_core), .dbg_bus_oe(dbg_bus_oe)
   );

   sram_grant_pick u_pick_tb (
      .jtag_ok(pk_j), .data_req(pk_d), .fetch_req(pk_f),
      .last_core(pk_last), .grant(pk_grant), .valid(pk_valid)
   );

   // ---------------- SRAM model ----------------
   logic [15:0] mem [0:65535];
   logic        pre_we;
   logic [15:0] pre_addr, pre_data;

   assign sram_data = (sram_en && !sram_wr) ? mem[sram_addr] : {16{1'bz}};

   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (sram_en && sram_wr) mem[sram_addr] <= sram_data;
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic set_req(input int who, input logic val, input logic wr,
                          input logic [15:0] a, input logic [15:0] wd);
      case (who)
         0: begin jtag_req = val; jtag_wr = wr; jtag_addr = a; jtag_wdata = wd; end
         1: begin data_req = val; data_wr = wr; data_addr = a; data_wdata = wd; end
         default: begin fetch_req = val; fetch_addr = a; end
      endcase
   endtask

   function automatic logic ack_of(input int who);
      case (who)
         0: return jtag_ack;
         1: return data_ack;
         default: return fetch_ack;
      endcase
   endfunction

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (dbg_state !== ST_IDLE && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("idle_wait", (n < 20), 1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_state"}, dbg_state, ST_IDLE);
      check({tag, "_acks"}, {jtag_ack, data_ack, fetch_ack}, 3'b000);
      check({tag, "_en"}, sram_en, 1'b0);
      check({tag, "_wr"}, sram_wr, 1'b0);
      check({tag, "_addr"}, sram_addr, 16'h0000);
      check({tag, "_rdata"}, rdata, 16'h0000);
      check({tag, "_bus_oe"}, dbg_bus_oe, 1'b0);
      check({tag, "_last_core"}, dbg_last_core, OWN_FETCH);
   endtask

   task automatic do_reset(input logic do_check);
      @(negedge clk);
      rstn = 1'b0;
      set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0); set_req(2, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      if (do_check) check_reset_values("rst");
      rstn = 1'b1;
   endtask

   // ---------------- vector tables ----------------
   typedef struct {
      logic   j, d, f;
      owner_t last;
      logic [2:0] g;
      logic   v;
   } pick_vec_t;

   typedef struct {
      int          who;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rd;
   } txn_vec_t;

   pick_vec_t pv[11];
   txn_vec_t  tv[9];

   task automatic single_txn(input int idx, input txn_vec_t v);
      int ack_c = -1;
      int en_first = -1;
      int en_cnt = 0;
      wait_idle();
      set_req(v.who, 1, v.wr, v.addr, v.wdata);
      for (int c = 1; c <= 10 && ack_c < 0; c++) begin
         @(negedge clk);
         if (sram_en) begin
            if (en_first < 0) en_first = c;
            en_cnt++;
            check($sformatf("t%0d_addr", idx), sram_addr, v.addr);
            check($sformatf("t%0d_wr", idx), sram_wr, v.wr);
            if (v.wr) check($sformatf("t%0d_bus", idx), sram_data, v.wdata);
         end
         if (jtag_ack || data_ack || fetch_ack) begin
            ack_c = c;
            check($sformatf("t%0d_ack_who", idx), {fetch_ack, data_ack, jtag_ack}, 32'd1 << v.who);
            check($sformatf("t%0d_rdata", idx), rdata, v.exp_rd);
            check($sformatf("t%0d_oe_done", idx), dbg_bus_oe, 1'b0);
            set_req(v.who, 0, 0, 0, 0);
         end
      end
      check($sformatf("t%0d_ack_cycle", idx), ack_c, AC + 1);
      check($sformatf("t%0d_en_first", idx), en_first, 1);
      check($sformatf("t%0d_en_cnt", idx), en_cnt, AC);
      if (v.wr) check($sformatf("t%0d_mem", idx), mem[v.addr], v.wdata);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int          ack_at[3];
      logic [15:0] rd_at[3];
      int          who_seq[4];
      int          cyc_seq[4];
      logic [15:0] rr_rd[4];
      int          n;
      int          fa[8];
      int          jtag_seen;
      int          jc;
      logic [15:0] jrd;
      int          ack_cnt;

      rstn = 1'b0; is_paused = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0); set_req(2, 0, 0, 0, 0);
      pk_j = 0; pk_d = 0; pk_f = 0; pk_last = OWN_FETCH;

      pv[0]  = '{0, 0, 0, OWN_FETCH, 3'b000, 0};
      pv[1]  = '{1, 0, 0, OWN_FETCH, 3'b001, 1};
      pv[2]  = '{0, 1, 0, OWN_FETCH, 3'b010, 1};
      pv[3]  = '{0, 0, 1, OWN_FETCH, 3'b100, 1};
      pv[4]  = '{0, 0, 1, OWN_DATA,  3'b100, 1};
      pv[5]  = '{0, 1, 0, OWN_DATA,  3'b010, 1};
      pv[6]  = '{0, 1, 1, OWN_FETCH, 3'b010, 1};
      pv[7]  = '{0, 1, 1, OWN_DATA,  3'b100, 1};
      pv[8]  = '{1, 1, 1, OWN_FETCH, 3'b001, 1};
      pv[9]  = '{1, 1, 1, OWN_DATA,  3'b001, 1};
      pv[10] = '{1, 0, 1, OWN_DATA,  3'b001, 1};

      tv[0] = '{2, 0, 16'h0100, 16'h0000, 16'h1357};
      tv[1] = '{0, 1, 16'h1234, 16'hA5A5, 16'h1357};
      tv[2] = '{1, 0, 16'h0040, 16'h0000, 16'hBEEF};
      tv[3] = '{1, 1, 16'h0200, 16'h0F0F, 16'hBEEF};
      tv[4] = '{0, 0, 16'h1234, 16'h0000, 16'hA5A5};
      tv[5] = '{2, 0, 16'h0200, 16'h0000, 16'h0F0F};
      tv[6] = '{1, 0, 16'hFFFF, 16'h0000, 16'h8001};
      tv[7] = '{0, 1, 16'h0000, 16'hFFFF, 16'h8001};
      tv[8] = '{2, 0, 16'h0000, 16'h0000, 16'hFFFF};

      // grant picker standalone
      for (int i = 0; i < 11; i++) begin
         pk_j = pv[i].j; pk_d = pv[i].d; pk_f = pv[i].f; pk_last = pv[i].last;
         #1;
         check($sformatf("pick%0d_grant", i), pk_grant, pv[i].g);
         check($sformatf("pick%0d_valid", i), pk_valid, pv[i].v);
      end

      preload(16'h0040, 16'hBEEF);
      preload(16'h0100, 16'h1357);
      preload(16'hFFFF, 16'h8001);
      do_reset(1'b1);

      // contention: all three at once while paused
      wait_idle();
      is_paused = 1'b1;
      set_req(0, 1, 0, 16'h0040, 0);
      set_req(1, 1, 0, 16'h0100, 0);
      set_req(2, 1, 0, 16'hFFFF, 0);
      for (int k = 0; k < 3; k++) begin ack_at[k] = -1; rd_at[k] = '0; end
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         check($sformatf("cont_en_c%0d", c), sram_en,
               (c < 12) && ((c % 4 == 1) || (c % 4 == 2)));
         check($sformatf("cont_onehot_c%0d", c), ($countones({jtag_ack, data_ack, fetch_ack}) <= 1), 1);
         for (int k = 0; k < 3; k++) begin
            if (ack_of(k)) begin
               ack_at[k] = c; rd_at[k] = rdata;
               set_req(k, 0, 0, 0, 0);
            end
         end
      end
      check("cont_jtag_cycle", ack_at[0], 3);
      check("cont_data_cycle", ack_at[1], 7);
      check("cont_fetch_cycle", ack_at[2], 11);
      check("cont_jtag_rdata", rd_at[0], 16'hBEEF);
      check("cont_data_rdata", rd_at[1], 16'h1357);
      check("cont_fetch_rdata", rd_at[2], 16'h8001);

      // round-robin between held data and fetch requests
      do_reset(1'b0);
      wait_idle();
      set_req(1, 1, 0, 16'h0040, 0);
      set_req(2, 1, 0, 16'h0100, 0);
      n = 0;
      for (int c = 1; c <= 20 && n < 4; c++) begin
         @(negedge clk);
         if (data_ack || fetch_ack) begin
            who_seq[n] = data_ack ? 1 : 2;
            cyc_seq[n] = c;
            rr_rd[n] = rdata;
            n++;
            if (n == 4) begin
               set_req(1, 0, 0, 0, 0);
               set_req(2, 0, 0, 0, 0);
            end
         end
      end
      check("rr_count", n, 4);
      for (int k = 0; k < 4; k++) begin
         if (k < n) begin
            check($sformatf("rr%0d_who", k), who_seq[k], (k % 2 == 0) ? 1 : 2);
            check($sformatf("rr%0d_cycle", k), cyc_seq[k], 3 + 4 * k);
            check($sformatf("rr%0d_rdata", k), rr_rd[k], (k % 2 == 0) ? 16'hBEEF : 16'h1357);
         end
      end

      // JTAG gated while not paused; fetch keeps running
      wait_idle();
      is_paused = 1'b0;
      set_req(0, 1, 0, 16'h0040, 0);
      set_req(2, 1, 0, 16'hFFFF, 0);
      n = 0; jtag_seen = 0;
      for (int c = 1; c <= 19; c++) begin
         @(negedge clk);
         if (jtag_ack) jtag_seen++;
         if (fetch_ack) begin
            if (n < 8) fa[n] = c;
            n++;
            fetch_req = 1'b0;
         end else begin
            fetch_req = 1'b1;
         end
      end
      check("gate_jtag_acks", jtag_seen, 0);
      check("gate_fetch_count", n, 5);
      for (int k = 0; k < 5; k++) begin
         if (k < n) check($sformatf("gate_fetch%0d_cycle", k), fa[k], 3 + 4 * k);
      end
      fetch_req = 1'b0;
      is_paused = 1'b1;
      jc = -1; jrd = '0; ack_cnt = 0;
      for (int c = 20; c <= 30 && jc < 0; c++) begin
         @(negedge clk);
         if (fetch_ack || data_ack) ack_cnt++;
         if (jtag_ack) begin
            jc = c; jrd = rdata;
            jtag_req = 1'b0;
         end
      end
      check("gate_jtag_cycle", jc, 23);
      check("gate_jtag_rdata", jrd, 16'hBEEF);
      check("gate_other_acks", ack_cnt, 0);

      // single transaction table
      for (int i = 0; i < 9; i++) single_txn(i, tv[i]);

      // reset in the second ACCESS cycle of a write
      wait_idle();
      set_req(1, 1, 1, 16'h0300, 16'h5555);
      @(negedge clk);
      @(negedge clk);
      check("abort_pre_en", sram_en, 1'b1);
      check("abort_pre_oe", dbg_bus_oe, 1'b1);
      rstn = 1'b0;
      #1;
      check_reset_values("abort");
      set_req(1, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      ack_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (jtag_ack || data_ack || fetch_ack) ack_cnt++;
      end
      check("abort_no_ack", ack_cnt, 0);
      check("abort_state", dbg_state, ST_IDLE);
      check("abort_last_core", dbg_last_core, OWN_FETCH);
      check("abort_en", sram_en, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
